tick_serial_tx: RTL
===================

Name: tick_serial_tx

Overview:
- Serial frame transmitter that sits directly downstream of the mode-dependent tick counter.
- Uses each counter pulse (`tick`) as a bit-period strobe: one bit per tick, LSB first, framed as start, data, optional parity, then stop.
- Parallel data enters through a valid/ready handshake; the serial line `tx` idles high.
- Provides the master/slave link's line driver; bit rate follows whichever mode is selected upstream.

Parameters:
- DATA_W, 8: data bits per frame (range 5..16).
- STOP_BITS, 1: stop-bit periods per frame (1 or 2).

Ports:
- clk, input, 1: single clock; all logic on posedge.
- reset_n, input, 1: synchronous, active-low reset.
- tick, input, 1: one-cycle bit-period strobe from the tick counter.
- in_valid, input, 1: in_data holds a frame to send.
- in_ready, output, 1: block can accept a frame; high exactly when in IDLE (decoded from the state register).
- in_data, input, DATA_W: payload, sampled only on accept.
- tx, output, 1: serial line, registered.
- busy, output, 1: high in any state other than IDLE.
- done, output, 1: one-cycle pulse when a frame's last stop bit completes.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (reset_n=0 at a posedge) forces:
  - state=IDLE, tx=1, done=0, busy=0, in_ready=1;
  - shift register and bit counter cleared.
  - Reset has priority over tick and handshake.
- Accept: occurs when in_valid && in_ready at a posedge.
  - in_data is loaded into the shift register and the state goes to ALIGN.
  - A tick in the accept cycle is ignored.
- States:
  - IDLE: tx=1; ticks ignored; waits for accept.
  - ALIGN: tx=1; on tick, tx<=0 (start bit) and go to START. Aligns the start bit to the tick grid.
  - START: on tick, tx<=shift[0], bit_cnt<=0, go to DATA.
  - DATA: on tick:
    - if bit_cnt==DATA_W-1, go to PARITY (feature on) with tx<=parity, or to STOP with tx<=1;
    - otherwise shift right, tx<=next bit, bit_cnt+1.
  - PARITY: on tick, tx<=1 and go to STOP.
  - STOP: on each tick, increment stop_cnt. On the STOP_BITS-th tick, go to IDLE with done<=1 for exactly one cycle.
- Width rules:
  - bit_cnt is $clog2(DATA_W) bits wide.
  - stop_cnt is 1 bit.
  - No wrap-around occurs inside a frame.
- Timing:
  - Every line bit lasts exactly one tick interval, measured tick edge to tick edge.
  - The frame occupies 1+DATA_W(+1)+STOP_BITS tick intervals after the align tick.
  - Back-to-back frames: in_ready rises in the same cycle done pulses, so an accept in that cycle is legal. The line stays high through ALIGN, giving a minimum inter-frame high time of STOP_BITS+1 periods.
- Boundary conditions:
  - in_valid dropping while not in IDLE has no effect.
  - in_data changes after accept are ignored.
  - Reset mid-frame aborts the frame: tx returns high at that edge and no done pulse is produced.
  - If tick stops (upstream counter idle), the block holds its current state and tx level indefinitely.
  - A tick asserted for multiple cycles counts once per cycle; the upstream counter guarantees single-cycle pulses.

Optional Feature:
- Macro: TICK_TX_PARITY_EN.
- Defined: a PARITY state is inserted after DATA.
  - tx = XOR of all DATA_W loaded bits (even parity).
  - Parity is computed at accept and held in a register.
  - Frame length = 2+DATA_W+STOP_BITS periods.
- Undefined: DATA goes directly to STOP; no parity register is instantiated; frame length = 1+DATA_W+STOP_BITS periods.

Decomposition:
- Package tick_tx_pkg holds:
  - typedef enum logic [2:0] tx_state_t {IDLE, ALIGN, START, DATA, PARITY, STOP};
  - localparam LINE_IDLE = 1'b1;
  - function frame_ticks(DATA_W, STOP_BITS, parity_en), used by the bench to compute frame length.
- No sub-module: the shift register, counters and FSM fit in one module.

Test Plan:
- Reset behaviour: reset_n=0 for 3 cycles mid-idle -> tx=1, in_ready=1, busy=0, done=0 on the first edge after reset.
- Single frame, no parity: tick every 25 cycles; accept 0xA5.
  - Sampled one cycle after each tick, tx = 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop).
  - done pulses once, 10 ticks after the align tick.
- Parity frame (TICK_TX_PARITY_EN defined):
  - 0xA5 -> parity bit 0.
  - 0x07 -> parity bit 1.
  - Each frame is 11 tick periods.
- Back-to-back with in_valid held high: two frames 0x3C then 0xC3 at a 50-cycle tick.
  - Second accept occurs in the done cycle.
  - Line stays high for exactly 2 periods between frames.
- Reset mid-DATA: assert reset_n=0 after the 4th data tick -> tx=1 next edge, no done pulse; the next frame 0x01 transmits cleanly.
- Tick/accept collision: tick coincident with the accept edge is ignored -> start bit begins only at the following tick (25 cycles later).

Source files
------------

// File: rtl/tick_tx_pkg.sv
// Shared types and helpers for the tick-paced serial transmitter.
// Optional parity build is selected with TICK_TX_PARITY_EN.
package tick_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;

    // Tick intervals from the align tick to the tick that ends the last stop bit.
    function automatic int unsigned frame_ticks(input int unsigned data_w,
                                                input int unsigned stop_bits,
                                                input bit          parity_en);
        return 1 + data_w + (parity_en ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/tick_serial_tx.sv
// Serial frame transmitter paced by an upstream bit-period tick: start, LSB-first data,
// optional even parity (TICK_TX_PARITY_EN), then STOP_BITS stop periods.
module tick_serial_tx
    import tick_tx_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int unsigned      CNT_W     = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              accept;
`ifdef TICK_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    assign in_ready = (state_q == IDLE);
    assign busy     = ~in_ready;
    assign accept   = in_valid & in_ready;
    assign tx       = tx_q;
    assign done     = done_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
`ifdef TICK_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = LINE_IDLE;
                // Ticks are ignored here, including one coincident with the accept.
                if (accept) begin
                    shift_d    = in_data;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    state_d    = ALIGN;
`ifdef TICK_TX_PARITY_EN
                    parity_d   = ^in_data;
`endif
                end
            end
            ALIGN: begin
                if (tick) begin
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef TICK_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = PARITY;
`else
                        tx_d    = LINE_IDLE;
                        state_d = STOP;
`endif
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef TICK_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    tx_d    = LINE_IDLE;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        stop_cnt_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = LINE_IDLE;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= LINE_IDLE;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

`ifdef TICK_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

endmodule
